// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port data-memory arbiter. Port A (CPU MEM stage) and port B
//            (loader/debug) share one synchronous-read data RAM. Each access
//            is serialised through IDLE -> ISSUE -> CAPTURE -> ACK, so a
//            request seen in IDLE is acknowledged three cycles later.
//            After ACK the other port is served back-to-back if it is waiting.
// Options  : DMEM_ARB_RR_EN - when defined, simultaneous requests are granted
//            round-robin using a last-owner register; when undefined, port A
//            always wins simultaneous requests.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module dmem_arbiter (
  input  logic        clk,
  input  logic        rst,
  // Port A: CPU MEM stage
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic [31:0] a_rdata,
  output logic        a_stall,
  // Port B: loader / debug
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic [31:0] b_rdata,
  output logic        b_stall,
  // Data RAM (synchronous read, data valid one cycle after ram_re)
  output logic        ram_re,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    ACK     = 2'd3
  } state_t;

  state_t      r_state;
  // Latched attributes of the in-flight access. The latched address and
  // write data live directly in ram_addr / ram_wdata so the RAM bus holds
  // the last latched values between accesses.
  logic        r_we;
  logic        r_owner_b;   // 0 = port A owns the access, 1 = port B

`ifdef DMEM_ARB_RR_EN
  logic        r_last_b;    // 1 = port B was granted most recently
`endif

  // Grant selection for the current cycle
  logic        w_take;      // a new access is latched at the next edge
  logic        w_sel_b;     // the access to latch comes from port B
  logic        w_sel_we;
  logic [31:0] w_sel_addr;
  logic [31:0] w_sel_wdata;

  // Pick the next winner: arbitration in IDLE, hand-over to the other port in ACK
  always_comb begin
    w_take  = 1'b0;
    w_sel_b = 1'b0;
    case (r_state)
      IDLE: begin
        w_take = a_req | b_req;
`ifdef DMEM_ARB_RR_EN
        // On a tie the port that was not granted last wins.
        w_sel_b = b_req & (~a_req | ~r_last_b);
`else
        // On a tie port A wins.
        w_sel_b = b_req & ~a_req;
`endif
      end
      ACK: begin
        // The owner's own request is ignored here; only the other port may
        // be served back-to-back.
        w_sel_b = ~r_owner_b;
        w_take  = r_owner_b ? a_req : b_req;
      end
      default: begin
        w_take  = 1'b0;
        w_sel_b = 1'b0;
      end
    endcase
    w_sel_we    = w_sel_b ? b_we    : a_we;
    w_sel_addr  = w_sel_b ? b_addr  : a_addr;
    w_sel_wdata = w_sel_b ? b_wdata : a_wdata;
  end

  // Access sequencer: latches the winner, strobes the RAM, captures read data, acks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_we      <= 1'b0;
      r_owner_b <= 1'b0;
      ram_addr  <= 32'h0;
      ram_wdata <= 32'h0;
      ram_re    <= 1'b0;
      ram_we    <= 1'b0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= 32'h0;
      b_rdata   <= 32'h0;
`ifdef DMEM_ARB_RR_EN
      r_last_b  <= 1'b1;
`endif
    end else begin
      // Strobes and acks are single-cycle pulses unless re-armed below.
      ram_re <= 1'b0;
      ram_we <= 1'b0;
      a_ack  <= 1'b0;
      b_ack  <= 1'b0;
      case (r_state)
        IDLE, ACK: begin
          if (w_take) begin
            r_we      <= w_sel_we;
            r_owner_b <= w_sel_b;
            ram_addr  <= w_sel_addr;
            ram_wdata <= w_sel_wdata;
            // Strobe is registered so it is high exactly during ISSUE.
            ram_re    <= ~w_sel_we;
            ram_we    <= w_sel_we;
`ifdef DMEM_ARB_RR_EN
            r_last_b  <= w_sel_b;
`endif
            r_state   <= ISSUE;
          end else begin
            r_state   <= IDLE;
          end
        end
        ISSUE: begin
          r_state <= CAPTURE;
        end
        CAPTURE: begin
          // Read data from the RAM is valid now; only the owner's register
          // is written, and only for reads.
          if (!r_we) begin
            if (r_owner_b) begin
              b_rdata <= ram_rdata;
            end else begin
              a_rdata <= ram_rdata;
            end
          end
          a_ack   <= ~r_owner_b;
          b_ack   <= r_owner_b;
          r_state <= ACK;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Stall holds the requester's pipeline until its ack arrives
  assign a_stall = a_req & ~a_ack;
  assign b_stall = b_req & ~b_ack;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Self-checking bench for dmem_arbiter. A transaction-level model
//            treats the arbiter as a single server: each granted access owns
//            the RAM for three cycles and takes effect on a reference memory
//            at grant time, so read results follow grant order.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        a_req, a_we, b_req, b_we;
  logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
  logic        a_ack, a_stall, b_ack, b_stall;
  logic [31:0] a_rdata, b_rdata;
  logic        ram_re, ram_we;
  logic [31:0] ram_addr, ram_wdata, ram_rdata;

  dmem_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .a_req     (a_req),
    .a_we      (a_we),
    .a_addr    (a_addr),
    .a_wdata   (a_wdata),
    .a_ack     (a_ack),
    .a_rdata   (a_rdata),
    .a_stall   (a_stall),
    .b_req     (b_req),
    .b_we      (b_we),
    .b_addr    (b_addr),
    .b_wdata   (b_wdata),
    .b_ack     (b_ack),
    .b_rdata   (b_rdata),
    .b_stall   (b_stall),
    .ram_re    (ram_re),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous-read data RAM, 64 words indexed by address bits [7:2]
  logic [31:0] ram [64];
  logic        pl_en = 1'b0;
  logic [5:0]  pl_idx = 6'd0;
  logic [31:0] pl_data = 32'h0;

  always @(posedge clk) begin
    if (pl_en) ram[pl_idx] <= pl_data;
    else if (ram_we) ram[ram_addr[7:2]] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_addr[7:2]];
  end

  // Reference model state
  logic [31:0] ref_mem [64];
  int          m_cnt;       // 0 idle, 1..3 = cycles since grant
  bit          m_own_b;
  bit          m_we;
  logic [31:0] m_addr, m_wdata, m_res;
  logic [31:0] m_rdata_a, m_rdata_b;
  bit          m_last_b;

  int n_vec = 0;
  int n_err = 0;
  int ram_we_count = 0;
  bit rand_mode = 1'b0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_own_b = 1'b0; m_we = 1'b0;
    m_addr = 32'h0; m_wdata = 32'h0; m_res = 32'h0;
    m_rdata_a = 32'h0; m_rdata_b = 32'h0;
    m_last_b = 1'b1;
  endtask

  // A grant takes effect on the reference memory immediately: accesses are serialised
  task automatic model_grant(input bit sel_b);
    m_own_b = sel_b;
    m_we    = sel_b ? b_we    : a_we;
    m_addr  = sel_b ? b_addr  : a_addr;
    m_wdata = sel_b ? b_wdata : a_wdata;
    if (m_we) ref_mem[m_addr[7:2]] = m_wdata;
    else      m_res = ref_mem[m_addr[7:2]];
    m_last_b = sel_b;
    m_cnt = 1;
  endtask

  task automatic commit();
    bit sel_b;
    if (m_cnt == 0) begin
      if (a_req || b_req) begin
`ifdef DMEM_ARB_RR_EN
        sel_b = b_req && (!a_req || !m_last_b);
`else
        sel_b = b_req && !a_req;
`endif
        model_grant(sel_b);
      end
    end else if (m_cnt == 3) begin
      if (m_own_b ? a_req : b_req) model_grant(!m_own_b);
      else m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == 3 && !m_we) begin
        if (m_own_b) m_rdata_b = m_res;
        else         m_rdata_a = m_res;
      end
    end
  endtask

  task automatic check_outputs();
    bit ea, eb;
    ea = (m_cnt == 3) && !m_own_b;
    eb = (m_cnt == 3) && m_own_b;
    check_val("a_ack",     64'(a_ack),     64'(ea));
    check_val("b_ack",     64'(b_ack),     64'(eb));
    check_val("a_stall",   64'(a_stall),   64'(a_req & ~ea));
    check_val("b_stall",   64'(b_stall),   64'(b_req & ~eb));
    check_val("ram_re",    64'(ram_re),    64'((m_cnt == 1) && !m_we));
    check_val("ram_we",    64'(ram_we),    64'((m_cnt == 1) && m_we));
    check_val("ram_addr",  64'(ram_addr),  64'(m_addr));
    check_val("ram_wdata", 64'(ram_wdata), 64'(m_wdata));
    check_val("a_rdata",   64'(a_rdata),   64'(m_rdata_a));
    check_val("b_rdata",   64'(b_rdata),   64'(m_rdata_b));
    if (ram_we === 1'b1) ram_we_count++;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] v;
    v = $urandom() & 32'hFFFF_FF00;
    v[4:2] = 3'($urandom_range(0, 7));
    return v;
  endfunction

  // Drops a request after its ack; in random mode also starts new requests and wiggles idle inputs
  task automatic drive_ports();
    bit ea, eb;
    ea = (m_cnt == 3) && !m_own_b;
    eb = (m_cnt == 3) && m_own_b;
    if (a_req && ea) a_req = 1'b0;
    else if (a_req) ea = 1'b0;
    if (rand_mode && !a_req) begin
      a_we = 1'($urandom_range(0, 1)); a_addr = rand_addr(); a_wdata = $urandom();
      a_req = ($urandom_range(0, 9) < (ea ? 2 : 3));
    end
    if (b_req && eb) b_req = 1'b0;
    else if (b_req) eb = 1'b0;
    if (rand_mode && !b_req) begin
      b_we = 1'($urandom_range(0, 1)); b_addr = rand_addr(); b_wdata = $urandom();
      b_req = ($urandom_range(0, 9) < (eb ? 2 : 3));
    end
  endtask

  task automatic sync_check();
    @(negedge clk);
    check_outputs();
    drive_ports();
  endtask

  task automatic cyc();
    sync_check();
    commit();
  endtask

  // Asserts reset mid-cycle, checks the immediate effect, releases at the next negedge
  task automatic apply_reset();
    rst = 1'b1;
    a_req = 1'b0; b_req = 1'b0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    check_outputs();
    rst = 1'b0;
  endtask

  // Counts cycles from the request cycle to each ack the DUT produces (bounded)
  task automatic run_acks(input bit want_a, input bit want_b, output int la, output int lb);
    la = -1; lb = -1;
    for (int n = 1; n <= 20; n++) begin
      sync_check();
      if (a_ack === 1'b1 && la < 0) la = n;
      if (b_ack === 1'b1 && lb < 0) lb = n;
      commit();
      if ((!want_a || la >= 0) && (!want_b || lb >= 0)) break;
    end
  endtask

  int la, lb, we0;
  bit first_b;

  initial begin
    a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
    b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    model_reset();
    #1 rst = 1'b1;

    // Preload RAM and reference memory while in reset
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      pl_en = 1'b1; pl_idx = 6'(i);
      pl_data = (i == 4) ? 32'hDEADBEEF : $urandom();
      ref_mem[i] = pl_data;
    end
    @(negedge clk);
    pl_en = 1'b0;
    apply_reset();

    // Single read from 0x10
    a_req = 1; a_we = 0; a_addr = 32'h10; a_wdata = 32'h0;
    commit();
    run_acks(1, 0, la, lb);
    check_val("rd_lat_a", 64'(la), 64'(3));
    check_val("rd_a_rdata", 64'(a_rdata), 64'(32'hDEADBEEF));

    // Port B writes 0x20 then reads it back
    we0 = ram_we_count;
    sync_check();
    b_req = 1; b_we = 1; b_addr = 32'h20; b_wdata = 32'h12345678;
    commit();
    run_acks(0, 1, la, lb);
    check_val("wr_lat_b", 64'(lb), 64'(3));
    sync_check();
    b_req = 1; b_we = 0; b_addr = 32'h20; b_wdata = 32'h0;
    commit();
    run_acks(0, 1, la, lb);
    check_val("rb_b_rdata", 64'(b_rdata), 64'(32'h12345678));
    check_val("rb_a_rdata", 64'(a_rdata), 64'(32'hDEADBEEF));
    check_val("rb_we_pulses", 64'(ram_we_count - we0), 64'(1));

    // Contention from reset, two rounds
    apply_reset();
    a_req = 1; a_we = 0; a_addr = 32'h10;
    b_req = 1; b_we = 0; b_addr = 32'h20;
    commit();
    run_acks(1, 1, la, lb);
    check_val("cont1_lat_a", 64'(la), 64'(3));
    check_val("cont1_lat_b", 64'(lb), 64'(6));
    sync_check();
`ifdef DMEM_ARB_RR_EN
    first_b = !m_last_b;
`else
    first_b = 1'b0;
`endif
    a_req = 1; a_we = 0; a_addr = 32'h20;
    b_req = 1; b_we = 0; b_addr = 32'h10;
    commit();
    run_acks(1, 1, la, lb);
    check_val("cont2_lat_a", 64'(la), 64'(first_b ? 6 : 3));
    check_val("cont2_lat_b", 64'(lb), 64'(first_b ? 3 : 6));

    // Reset while an A read is in CAPTURE, then a fresh read
    sync_check();
    a_req = 1; a_we = 0; a_addr = 32'h10;
    commit();
    cyc();
    sync_check();
    apply_reset();
    commit();
    cyc(); cyc(); cyc();
    check_val("rst_a_rdata", 64'(a_rdata), 64'(0));
    sync_check();
    a_req = 1; a_we = 0; a_addr = 32'h10;
    commit();
    run_acks(1, 0, la, lb);
    check_val("post_rst_lat_a", 64'(la), 64'(3));
    check_val("post_rst_a_rdata", 64'(a_rdata), 64'(32'hDEADBEEF));

    // Random traffic on both ports, then drain
    rand_mode = 1'b1;
    repeat (3000) cyc();
    rand_mode = 1'b0;
    repeat (16) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
